// File: rtl/awg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// awg_pkg: types and constants shared by the AWG serial blocks. Rev 1.0
// ------------------------------------------------------------------
package awg_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_fifo: single-clock show-ahead FIFO with wrap-bit pointers. Rev 1.0
// ------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_transmitter: 8N1 serial transmitter fed by a byte FIFO. Rev 1.0
// ------------------------------------------------------------------
module uart_transmitter
   import awg_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [UART_DATA_BITS-1:0]     tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t              state_q, state_d;
   logic [CNT_W-1:0]            baud_q, baud_d;
   logic [2:0]                  bit_q, bit_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic                        tx_q, tx_d;

   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [UART_DATA_BITS-1:0]   fifo_dout;
   logic                        baud_done;

   assign fifo_push = tx_valid && !fifo_full;
   assign baud_done = (baud_q == BAUD_LAST);

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = START;
         START:   if (baud_done) state_d = DATA;
         DATA:    if (baud_done && (bit_q == BIT_LAST)) state_d = STOP;
         STOP:    if (baud_done) state_d = fifo_empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = 1'b0;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
            end
         end
         START: begin
            baud_d = baud_done ? '0 : baud_q + 1'b1;
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = bit_q + 3'd1;
               shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d = '0;
               bit_d  = '0;
               // Reload straight from the FIFO so the next start bit follows with no idle gap.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            baud_d = '0;
            bit_d  = '0;
         end
      endcase

      // Line level is registered from the next state so it changes on the edge that enters it.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign uart_tx  = tx_q;
   assign tx_ready = !fifo_full;
   assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_transmitter: randomized frame-level bench for uart_transmitter. Rev 1.0
// ------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       uart_tx;
   logic       busy;
   logic [3:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];
   int         n_frames = 0;

   int             mon_cnt = -1;
   int             mon_start = 0;
   logic [FRAME-1:0] mon_bits;
   logic [9:0]     mon_lv;
   logic           mon_ok;
   logic [7:0]     mon_want;

   uart_transmitter #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Line decoder: collects whole frames and compares them with the queue of accepted bytes.
   task automatic monitor_sample();
      if (rst !== 1'b1) begin
         mon_cnt = -1;
      end else if (mon_cnt < 0) begin
         if (uart_tx === 1'b0) begin
            mon_bits  = '0;
            mon_start = cyc;
            mon_cnt   = 1;
         end
      end else begin
         mon_bits[mon_cnt] = uart_tx;
         mon_cnt++;
         if (mon_cnt == FRAME) begin
            mon_cnt = -1;
            mon_ok  = 1'b1;
            for (int b = 0; b < 10; b++) begin
               mon_lv[b] = mon_bits[b*CPB];
               for (int c = 1; c < CPB; c++)
                  if (mon_bits[b*CPB+c] !== mon_bits[b*CPB]) mon_ok = 1'b0;
            end
            n_checks++;
            if (!mon_ok || mon_lv[0] !== 1'b0 || mon_lv[9] !== 1'b1) begin
               n_fail++;
               $display("FAIL frame_shape at cycle %0d: line %b, required start 0, stop 1, each bit %0d cycles",
                        mon_start, mon_bits, CPB);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame_data at cycle %0d: got unexpected byte 0x%02h, required no frame",
                        mon_start, mon_lv[8:1]);
            end else begin
               mon_want = exp_q.pop_front();
               if (mon_lv[8:1] !== mon_want) begin
                  n_fail++;
                  $display("FAIL frame_data at cycle %0d: got 0x%02h, required 0x%02h",
                           mon_start, mon_lv[8:1], mon_want);
               end
            end
            start_q.push_back(mon_start);
            n_frames++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      monitor_sample();
      #1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      step();
      n_checks++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing: %0d frames never seen, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tx_valid = 1'b0;
      repeat (3) step();
      n_checks++;
      if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
      n_checks++;
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_byte();
      logic [7:0] d;
      logic [9:0] line;
      for (int t = 0; t < 4; t++) begin
         d    = (t == 0) ? 8'hA5 : 8'($urandom);
         line = {1'b1, d, 1'b0};
         tx_valid = 1'b1;
         tx_data  = d;
         step();
         tx_valid = 1'b0;
         exp_q.push_back(d);
         n_checks++;
         if (fifo_level !== 4'd1 || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: level=%0d tx=%b, required level=1 tx=1", fifo_level, uart_tx);
         end
         for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == 0) begin
               n_checks++;
               if (fifo_level !== 4'd0 || busy !== 1'b1) begin
                  n_fail++;
                  $display("FAIL single_pop: level=%0d busy=%b, required level=0 busy=1", fifo_level, busy);
               end
            end
            n_checks++;
            if (uart_tx !== line[i/CPB]) begin
               n_fail++;
               $display("FAIL single_line byte 0x%02h cycle %0d: got %b, required %b", d, i, uart_tx, line[i/CPB]);
            end
         end
         wait_idle(20, "single");
         n_checks++;
         if (busy !== 1'b0 || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after: busy=%b tx=%b, required busy=0 tx=1", busy, uart_tx);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      int base;
      for (int p = 0; p < 3; p++) begin
         a = (p == 0) ? 8'h00 : 8'($urandom);
         b = (p == 0) ? 8'hFF : 8'($urandom);
         base = n_frames;
         tx_valid = 1'b1;
         tx_data  = a;
         step();
         tx_data  = b;
         step();
         tx_valid = 1'b0;
         exp_q.push_back(a);
         exp_q.push_back(b);
         wait_idle(3 * FRAME, "b2b");
         n_checks++;
         if (n_frames != base + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames, required 2", n_frames - base);
         end else if (start_q[base+1] - start_q[base] != FRAME) begin
            n_fail++;
            $display("FAIL b2b_gap: start spacing %0d cycles, required %0d", start_q[base+1] - start_q[base], FRAME);
         end
      end
   endtask

   task automatic test_fill();
      logic [7:0] d;
      int base;
      int n;
      base = n_frames;
      d = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
      exp_q.push_back(d);
      repeat (3) step();
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         tx_valid = 1'b1;
         tx_data  = d;
         n_checks++;
         if (tx_ready !== (i < DEPTH)) begin
            n_fail++;
            $display("FAIL fill_ready push %0d: got %b, required %b", i, tx_ready, (i < DEPTH));
         end
         if (i < DEPTH) exp_q.push_back(d);
         step();
      end
      tx_valid = 1'b0;
      n_checks++;
      if (fifo_level !== 4'(DEPTH) || tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: level=%0d ready=%b, required level=%0d ready=0", fifo_level, tx_ready, DEPTH);
      end
      n = 0;
      while (fifo_level === 4'(DEPTH) && n < 2 * FRAME) begin
         step();
         n++;
      end
      n_checks++;
      if (n >= 2 * FRAME) begin
         n_fail++;
         $display("FAIL fill_pop_timeout: level=%0d after %0d cycles, required %0d", fifo_level, n, DEPTH - 1);
      end
      n_checks++;
      if (fifo_level !== 4'(DEPTH - 1) || tx_ready !== 1'b1 || uart_tx !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_unfull: level=%0d ready=%b tx=%b, required level=%0d ready=1 tx=0",
                  fifo_level, tx_ready, uart_tx, DEPTH - 1);
      end
      wait_idle(10 * FRAME + 20, "fill");
      n_checks++;
      if (n_frames - base != DEPTH + 1) begin
         n_fail++;
         $display("FAIL fill_count: got %0d frames, required %0d", n_frames - base, DEPTH + 1);
      end
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] d;
      int base;
      int n;
      base = n_frames;
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         tx_valid = 1'b1;
         tx_data  = d;
         exp_q.push_back(d);
         step();
      end
      tx_valid = 1'b0;
      n_checks++;
      if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL simul_setup: level=%0d, required 4", fifo_level); end
      n = 0;
      while (fifo_level !== 4'd3 && n < 2 * FRAME) begin
         step();
         n++;
      end
      repeat (FRAME - 1) step();
      n_checks++;
      if (fifo_level !== 4'd3 || uart_tx !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_stop: level=%0d tx=%b, required level=3 tx=1", fifo_level, uart_tx);
      end
      d = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = d;
      exp_q.push_back(d);
      step();
      tx_valid = 1'b0;
      n_checks++;
      if (fifo_level !== 4'd3 || uart_tx !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_edge: level=%0d tx=%b, required level=3 tx=0", fifo_level, uart_tx);
      end
      wait_idle(7 * FRAME, "simul");
      n_checks++;
      if (n_frames - base != 6) begin
         n_fail++;
         $display("FAIL simul_count: got %0d frames, required 6", n_frames - base);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      logic [7:0] e;
      d = 8'($urandom) & 8'hF7;
      e = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_data  = e;
      step();
      tx_valid = 1'b0;
      repeat (17) step();
      n_checks++;
      if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: got %b, required 0", uart_tx); end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if (uart_tx !== 1'b1 || fifo_level !== 4'd0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_async: tx=%b level=%0d busy=%b ready=%b, required 1 0 0 1",
                  uart_tx, fifo_level, busy, tx_ready);
      end
      exp_q.delete();
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         n_checks++;
         if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle cycle %0d: tx=%b busy=%b, required tx=1 busy=0", i, uart_tx, busy);
         end
      end
      d = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
      exp_q.push_back(d);
      wait_idle(2 * FRAME, "rstmid");
   endtask

   task automatic test_idle_soak();
      for (int i = 0; i < 1000; i++) begin
         step();
         n_checks++;
         if (uart_tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL soak cycle %0d: tx=%b busy=%b ready=%b level=%0d, required 1 0 1 0",
                     i, uart_tx, busy, tx_ready, fifo_level);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_fill();
      test_simul_push_pop();
      test_reset_mid_frame();
      test_idle_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
